// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - Request, status and data-memory signal bundle for mem_copy_engine
// Request : start, src_addr[7:0], dst_addr[7:0], length[6:0]
// Status  : busy, done, error, checksum[7:0]
// Memory  : mem_address[7:0], mem_write_data[7:0], mem_write_enable, mem_read_data[7:0]
// Modports: slave = the copy engine; master = the requester together with the data memory.
interface mem_copy_engine_if;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write_enable;
  logic [7:0] mem_read_data;

  modport slave (
    input  start, src_addr, dst_addr, length, mem_read_data,
    output busy, done, error, checksum, mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output start, src_addr, dst_addr, length, mem_read_data,
    input  busy, done, error, checksum, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - Byte-wise ascending memory copy engine with window check and checksum
// Parameters: MEM_BASE (lowest valid byte address), MEM_DEPTH (number of valid bytes).
// Ports     : clk, rst_n (asynchronous, active-low), bus (mem_copy_engine_if.slave).
// Option    : MEM_COPY_CHECKSUM_EN builds the running byte-sum accumulator; without it checksum is 8'h00.
// Each byte costs one read cycle (RD) and one write cycle (WR); write data is taken straight from
// the registered memory read data that arrives during WR.
module mem_copy_engine #(
  parameter int MEM_BASE  = 64,
  parameter int MEM_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_copy_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, DONE} state_t;

  // Window bounds in 9 bits so a copy that wraps past 8'hFF lands above the window.
  localparam logic [8:0] LP_LO = 9'(MEM_BASE);
  localparam logic [8:0] LP_HI = 9'(MEM_BASE + MEM_DEPTH - 1);

  state_t     r_state;
  logic [7:0] r_src;
  logic [7:0] r_dst;
  logic [6:0] r_len;
  logic [6:0] r_idx;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic       r_we;
  logic [7:0] r_addr;

  logic [8:0] w_src_last;
  logic [8:0] w_dst_last;
  logic       w_fault;
  logic [6:0] w_idx_next;

  // Last byte addresses; only meaningful for length > 0, which w_fault enforces.
  assign w_src_last = {1'b0, r_src} + {2'b00, r_len} - 9'd1;
  assign w_dst_last = {1'b0, r_dst} + {2'b00, r_len} - 9'd1;

  assign w_fault = (r_len > 7'd64) ||
                   ((r_len != 7'd0) &&
                    (({1'b0, r_src} < LP_LO) || (w_src_last > LP_HI) ||
                     ({1'b0, r_dst} < LP_LO) || (w_dst_last > LP_HI)));

  assign w_idx_next = r_idx + 7'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_src   <= bus.src_addr;
            r_dst   <= bus.dst_addr;
            r_len   <= bus.length;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_idx <= '0;
          if (w_fault) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_len == 7'd0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_addr  <= r_src;
            r_state <= RD;
          end
        end
        RD: begin
          r_addr  <= r_dst + {1'b0, r_idx};
          r_we    <= 1'b1;
          r_state <= WR;
        end
        WR: begin
          r_idx <= w_idx_next;
          r_we  <= 1'b0;
          if (w_idx_next < r_len) begin
            r_addr  <= r_src + {1'b0, w_idx_next};
            r_state <= RD;
          end else begin
            r_addr  <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_checksum <= '0;
    end else if (r_state == WR) begin
      r_checksum <= r_checksum + bus.mem_read_data;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = 8'h00;
`endif

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.error            = r_error;
  assign bus.mem_address      = r_addr;
  assign bus.mem_write_enable = r_we;
  // r_we is high only in WR, so write data is forced to zero in every other state.
  assign bus.mem_write_data   = r_we ? bus.mem_read_data : 8'h00;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - Directed bench for mem_copy_engine with per-cycle trace model
module tb_mem_copy_engine;

`ifdef MEM_COPY_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam int BASE  = 64;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] ck;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  mem_copy_engine_if bus();

  mem_copy_engine #(.MEM_BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  int         wr_count = 0;
  int         checks = 0;
  int         failures = 0;
  obs_t       q[$];
  logic       idle_err = 1'b0;
  logic [7:0] idle_ck = 8'h00;
  logic       pend_valid = 1'b0;
  logic [7:0] pend_a;
  logic [7:0] pend_d;

  // Data memory with one-cycle registered read.
  always @(posedge clk) begin
    bus.mem_read_data <= mem[bus.mem_address];
    if (bus.mem_write_enable === 1'b1) begin
      mem[bus.mem_address] = bus.mem_write_data;
      wr_count++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic obs_t obs_now();
    obs_t o;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.err   = bus.error;
    o.addr  = bus.mem_address;
    o.we    = bus.mem_write_enable;
    o.wdata = bus.mem_write_data;
    o.ck    = bus.checksum;
    return o;
  endfunction

  // Compare process: one expected tuple per cycle from the trace, idle tuple otherwise.
  always @(negedge clk or negedge rst_n) begin
    obs_t e;
    if (!rst_n) begin
      #1;
      q.delete();
      pend_valid = 1'b0;
      idle_err   = 1'b0;
      idle_ck    = 8'h00;
      chk("reset_outputs", 32'(obs_now()), 32'd0);
    end else begin
      if (pend_valid) begin
        exp_mem[pend_a] = pend_d;
        pend_valid = 1'b0;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        idle_err = e.err;
        idle_ck  = e.ck;
        if (e.we) begin
          pend_valid = 1'b1;
          pend_a     = e.addr;
          pend_d     = e.wdata;
        end
      end else begin
        e       = '0;
        e.err   = idle_err;
        e.ck    = idle_ck;
      end
      chk("cycle_outputs", 32'(obs_now()), 32'(e));
    end
  end

  task automatic preload(input int a, input logic [7:0] v);
    mem[a]     = v;
    exp_mem[a] = v;
  endtask

  // Builds the expected per-cycle trace from the copy rules, then issues start.
  // Entered and left at posedge+1.
  task automatic push_and_start(input int src, input int dst, input int len, output int exp_dc);
    logic [7:0] scratch [256];
    obs_t       e;
    int         sum;
    bit         fault;
    logic [7:0] v;
    scratch = exp_mem;
    fault = (len > 64) ||
            ((len > 0) && ((src < BASE) || (src + len - 1 > BASE + DEPTH - 1) ||
                           (dst < BASE) || (dst + len - 1 > BASE + DEPTH - 1)));
    e = '0; e.err = idle_err; e.ck = idle_ck; q.push_back(e);
    e = '0; e.busy = 1'b1; q.push_back(e);
    sum = 0;
    if (!fault) begin
      for (int i = 0; i < len; i++) begin
        v = scratch[(src + i) % 256];
        e = '0; e.busy = 1'b1; e.addr = 8'(src + i); e.ck = CK_EN ? 8'(sum) : 8'h00;
        q.push_back(e);
        e.addr = 8'(dst + i); e.we = 1'b1; e.wdata = v;
        q.push_back(e);
        scratch[(dst + i) % 256] = v;
        sum += int'(v);
      end
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = fault; e.ck = CK_EN ? 8'(sum) : 8'h00;
    q.push_back(e);
    exp_dc = (fault || len == 0) ? 2 : 2 * len + 2;
    bus.start    = 1'b1;
    bus.src_addr = 8'(src);
    bus.dst_addr = 8'(dst);
    bus.length   = 7'(len);
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask

  // Runs a copy to completion; dc is the cycle (counted from the start edge) where done is seen.
  task automatic do_copy(input int src, input int dst, input int len, input bit junk, output int dc);
    int exp_dc;
    push_and_start(src, dst, len, exp_dc);
    dc = 0;
    for (int c = 1; c <= 200 && dc == 0; c++) begin
      if (junk) begin
        if (c >= 2 && c <= 5) begin
          bus.start = 1'b1; bus.src_addr = 8'd70; bus.dst_addr = 8'd90; bus.length = 7'd2;
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done === 1'b1) dc = c;
      else @(posedge clk) #1;
    end
    chk("done_cycle", 32'(dc), 32'(exp_dc));
    @(posedge clk) #1;
    chk("trace_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int dc;
    int w0;
    int bad;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    for (int a = 0; a < 256; a++) preload(a, 8'h00);
    rst_n = 1'b0;
    preload(64, 8'd11); preload(65, 8'd22); preload(66, 8'd33); preload(67, 8'd44);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_wen", 32'(bus.mem_write_enable), 32'd0);
    rst_n = 1'b1;

    // Basic copy, started on the first edge after reset release.
    do_copy(64, 100, 4, 1'b0, dc);
    chk("t1_done_cycle_lit", 32'(dc), 32'd10);
    chk("t1_mem100", 32'(mem[100]), 32'd11);
    chk("t1_mem101", 32'(mem[101]), 32'd22);
    chk("t1_mem102", 32'(mem[102]), 32'd33);
    chk("t1_mem103", 32'(mem[103]), 32'd44);
    chk("t1_checksum_lit", 32'(bus.checksum), CK_EN ? 32'h6E : 32'h00);
    chk("t1_error", 32'(bus.error), 32'd0);

    // Zero length.
    w0 = wr_count;
    do_copy(64, 64, 0, 1'b0, dc);
    chk("t2_done_cycle_lit", 32'(dc), 32'd2);
    chk("t2_no_writes", 32'(wr_count - w0), 32'd0);
    chk("t2_error", 32'(bus.error), 32'd0);

    // Source range runs past the window.
    w0 = wr_count;
    do_copy(120, 64, 10, 1'b0, dc);
    chk("t3_error_lit", 32'(bus.error), 32'd1);
    chk("t3_done_cycle_lit", 32'(dc), 32'd2);
    chk("t3_no_writes", 32'(wr_count - w0), 32'd0);

    // Ascending overlap propagates; also clears the previous error.
    preload(64, 8'd1); preload(65, 8'd2); preload(66, 8'd3);
    do_copy(64, 65, 3, 1'b0, dc);
    chk("t4_error_cleared", 32'(bus.error), 32'd0);
    chk("t4_mem65", 32'(mem[65]), 32'd1);
    chk("t4_mem66", 32'(mem[66]), 32'd1);
    chk("t4_mem67", 32'(mem[67]), 32'd1);
    chk("t4_checksum_lit", 32'(bus.checksum), CK_EN ? 32'h03 : 32'h00);

    // Start pulses while busy are ignored.
    preload(64, 8'd5); preload(65, 8'd6); preload(66, 8'd7); preload(67, 8'd8);
    preload(90, 8'hAA); preload(91, 8'hBB);
    do_copy(64, 110, 4, 1'b1, dc);
    chk("t5_done_cycle_lit", 32'(dc), 32'd10);
    chk("t5_mem110", 32'(mem[110]), 32'd5);
    chk("t5_mem113", 32'(mem[113]), 32'd8);
    chk("t5_mem90_untouched", 32'(mem[90]), 32'hAA);
    chk("t5_checksum_lit", 32'(bus.checksum), CK_EN ? 32'h1A : 32'h00);

    // Reset during WR of byte 2 of 4.
    preload(64, 8'h10); preload(65, 8'h20); preload(66, 8'h30); preload(67, 8'h40);
    preload(80, 8'hE0); preload(81, 8'hE1); preload(82, 8'hE2); preload(83, 8'hE3);
    push_and_start(64, 80, 4, dc);
    repeat (6) @(posedge clk) #1;
    chk("t6_in_write", 32'(bus.mem_address), 32'd82);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk) #1;
    chk("t6_mem80", 32'(mem[80]), 32'h10);
    chk("t6_mem81", 32'(mem[81]), 32'h20);
    chk("t6_mem82", 32'(mem[82]), 32'hE2);
    chk("t6_mem83", 32'(mem[83]), 32'hE3);

    // Window boundaries: full window, last byte, below base, oversize, destination wrap.
    do_copy(64, 64, 64, 1'b0, dc);
    chk("t7_full_window_cycles", 32'(dc), 32'd130);
    do_copy(127, 64, 1, 1'b0, dc);
    chk("t7_last_byte_ok", 32'(bus.error), 32'd0);
    do_copy(63, 64, 1, 1'b0, dc);
    chk("t7_below_base", 32'(bus.error), 32'd1);
    do_copy(64, 64, 65, 1'b0, dc);
    chk("t7_len65", 32'(bus.error), 32'd1);
    do_copy(64, 250, 8, 1'b0, dc);
    chk("t7_dst_wrap", 32'(bus.error), 32'd1);
    do_copy(64, 127, 1, 1'b0, dc);
    chk("t7_dst_top_ok", 32'(bus.error), 32'd0);

    repeat (2) @(posedge clk) #1;
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
    chk("memory_image", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter MEM_BASE, default 64: lowest valid data-memory byte address.
REQ-002 Parameter MEM_DEPTH, default 64: number of valid data-memory bytes, MEM_BASE..MEM_BASE+MEM_DEPTH-1.
REQ-003 Port clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port start  in  1  copy request, sampled only in IDLE.
REQ-006 Port src_addr  in  8  first source byte address.
REQ-007 Port dst_addr  in  8  first destination byte address.
REQ-008 Port length  in  7  byte count, 0..64.
REQ-009 Port busy  out  1  high in every state except IDLE.
REQ-010 Port done  out  1  one-cycle completion pulse.
REQ-011 Port error  out  1  sticky fault flag, cleared on next accepted start.
REQ-012 Port mem_address  out  8  data-memory address.
REQ-013 Port mem_write_data  out  8  data-memory write data.
REQ-014 Port mem_write_enable  out  1  data-memory write strobe; low means read.
REQ-015 Port mem_read_data  in  8  data-memory registered read data, valid the cycle after the read address is presented.
REQ-016 Port checksum  out  8  running sum of copied bytes.

Function
REQ-017 States: IDLE, CHECK, RD, WR, DONE.
REQ-018 IDLE with start=1 at an edge: latch src_addr, dst_addr and length, clear error and checksum, go to CHECK; start while busy is ignored.
REQ-019 CHECK (1 cycle): fault if length>64, or length>0 and either [src, src+length-1] or [dst, dst+length-1] falls outside the MEM_BASE window; use 9-bit sums so that 8-bit address wrap counts as out of range.
REQ-020 CHECK outcome: fault -> error=1, go to DONE with no memory write; length=0 -> DONE; otherwise -> RD with byte index i=0.
REQ-021 RD: mem_address=src+i, mem_write_enable=0; next state WR.
REQ-022 WR: mem_address=dst+i, mem_write_data=mem_read_data, mem_write_enable=1; checksum += mem_read_data mod 256; i++; next state RD if i<length, else DONE.
REQ-023 Each byte takes exactly 2 cycles; N bytes take 2N+2 cycles from the start edge to the done pulse (CHECK + 2N + DONE).
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; error stays valid through DONE and IDLE until the next accepted start.
REQ-025 Overlap is permitted; the copy is strictly ascending byte by byte, so dst>src with overlap propagates bytes already written.
REQ-026 In IDLE, CHECK and DONE: mem_write_enable=0, mem_address=0, mem_write_data=0.

Reset
REQ-027 rst_n low forces, asynchronously: state=IDLE, busy=0, done=0, error=0, checksum=0, mem_address=0, mem_write_data=0, mem_write_enable=0, latched registers=0.
REQ-028 Reset during a copy aborts it immediately; bytes already written stay in memory, and no done pulse is produced.
REQ-029 The first start is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro MEM_COPY_CHECKSUM_EN defined: checksum accumulates as described in REQ-022 and holds its final value until the next accepted start.
REQ-031 Macro MEM_COPY_CHECKSUM_EN undefined: no accumulator is built, and checksum is tied to 8'h00.

Verification
REQ-032 Memory preloaded 64..67 = 11,22,33,44; start src=64 dst=100 len=4 -> addresses 100..103 hold 11,22,33,44; done pulses on the 10th cycle after the start edge; checksum=0x6E; error=0.
REQ-033 start len=0 src=64 dst=64 -> done on the 2nd cycle; no cycle with write_enable=1; error=0.
REQ-034 start src=120 dst=64 len=10 -> error=1, done on the 2nd cycle, no writes; next valid start clears error.
REQ-035 Memory 64..66 = 1,2,3; start src=64 dst=65 len=3 -> 65..67 = 1,1,1 (ascending overlap).
REQ-036 rst_n pulsed low during WR of byte 2 of 4 -> all outputs 0 immediately; bytes 0..1 written, bytes 2..3 unchanged; no done pulse.
REQ-037 start reasserted while busy -> ignored; the in-flight copy completes unchanged.
